// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI responder.
// State encoding, synchronizer depth and default frame width live here so the
// core and its synchronizer agree on them.
package spi_slave_pkg;

  // Responder FSM states; WAIT_IDLE is entered from reset.
  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } spi_state_t;

  // Flip-flops in each pin synchronizer.
  localparam int SPI_SYNC_STAGES = 2;

  // Default frame length in bits.
  localparam int SPI_DATA_W_DEFAULT = 32;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized value. The reset value of the
// chain is a parameter so that a select line can start out "asserted" and
// never produce a spurious edge straight out of reset.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_STAGES,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  // Shift the pin through the synchronizer and remember the previous output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign dout = sync_reg[STAGES-1];
  assign rise = dout & ~prev_reg;
  assign fall = ~dout & prev_reg;

endmodule

// File: rtl/spi_slave_core.sv
// Mode-0, MSB-first SPI responder oversampled on the system clock.
// Receives DATA_W-bit frames on mosi, replies with a preloaded word on miso,
// and supports back-to-back frames under one select.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to enable the sticky
// rx_overrun flag; otherwise rx_overrun is tied low.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              rx_overrun,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_W);

  // Synchronized pins and edge pulses.
  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  // Select resets to "asserted" so a reset taken mid-frame waits for a real
  // deselect instead of seeing a phantom falling edge.
  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .din(ss_n),
    .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(mosi),
    .dout(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              reload_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_full_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              miso_reg;
  logic              underrun_reg;
  logic              abort_reg;

  logic              complete;
  logic              load_req;
  logic              load_underrun;
  logic              handshake;
  logic [DATA_W-1:0] load_word;

  // A frame completes the cycle after the last bit has been shifted in.
  // A reload happens at frame start, or on the first fall after completion
  // unless select is dropping at the same time (the trailing fall of the
  // final frame must not consume the holding register).
  always_comb begin
    complete      = (state_reg == SHIFT) && (cnt_reg == CNT_DONE);
    load_req      = ((state_reg == IDLE) && ss_fall) ||
                    ((state_reg == SHIFT) && reload_reg && sclk_fall && !ss_rise);
    load_underrun = !hold_full_reg && !tx_valid;
    load_word     = '0;
    if (hold_full_reg) begin
      load_word = hold_data_reg;
    end else if (tx_valid) begin
      load_word = tx_data;
    end
    // A load from an empty register with tx_valid high is a bypass and
    // consumes the word, so it must not also fill the holding register.
    handshake     = tx_valid && !hold_full_reg && !load_req;
  end

  // Holding register: filled by the user handshake, emptied by a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else if (load_req && hold_full_reg) begin
      hold_full_reg <= 1'b0;
    end else if (handshake) begin
      hold_full_reg <= 1'b1;
      hold_data_reg <= tx_data;
    end
  end

  // Main FSM: frame framing, bit counting, shift registers and abort pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= WAIT_IDLE;
      cnt_reg      <= '0;
      reload_reg   <= 1'b0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      abort_reg    <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        WAIT_IDLE: begin
          if (ss_s) state_reg <= IDLE;
        end
        IDLE: begin
          if (ss_fall) begin
            state_reg    <= SHIFT;
            cnt_reg      <= '0;
            reload_reg   <= 1'b0;
            tx_shift_reg <= load_word;
          end
        end
        SHIFT: begin
          if (complete) begin
            cnt_reg    <= '0;
            reload_reg <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
            cnt_reg      <= cnt_reg + 1'b1;
          end
          if (load_req) begin
            tx_shift_reg <= load_word;
            reload_reg   <= 1'b0;
          end else if (sclk_fall && !reload_reg) begin
            tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
          end
          if (ss_rise) begin
            state_reg  <= IDLE;
            reload_reg <= 1'b0;
            if (cnt_reg != '0 && cnt_reg != CNT_DONE) abort_reg <= 1'b1;
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

  // Receive side: publish completed frames; a same-cycle ack loses to new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else if (complete) begin
      rx_data_reg  <= rx_shift_reg;
      rx_valid_reg <= 1'b1;
    end else if (rx_ack) begin
      rx_valid_reg <= 1'b0;
    end
  end

  // Registered pin and pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      miso_reg     <= (state_reg == SHIFT) ? tx_shift_reg[DATA_W-1] : 1'b0;
      underrun_reg <= load_req && load_underrun;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_reg;

  // Sticky overrun: a frame landed on unread data without a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_reg <= 1'b0;
    end else if (complete && rx_valid_reg && !rx_ack) begin
      overrun_reg <= 1'b1;
    end else if (rx_ack) begin
      overrun_reg <= 1'b0;
    end
  end

  assign rx_overrun = overrun_reg;
`else
  assign rx_overrun = 1'b0;
`endif

  assign miso        = miso_reg;
  assign miso_oe     = (state_reg == SHIFT);
  assign busy        = (state_reg == SHIFT);
  assign tx_ready    = !hold_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = underrun_reg;
  assign frame_abort = abort_reg;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: a behavioural SPI master drives the
// pins while a frame-level model predicts replies, received words and flags.
module tb_spi_slave_core;

  localparam int DATA_W = 32;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sclk, ss_n, mosi;
  logic              miso, miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ack;
  logic              tx_underrun, frame_abort, rx_overrun, busy;

  int checks = 0;
  int errors = 0;

  spi_slave_core #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ack(rx_ack), .tx_underrun(tx_underrun), .frame_abort(frame_abort),
    .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses and rx_valid rising edges.
  int n_underrun = 0, n_abort = 0, n_rv_rise = 0, rv_rise_cyc = 0;
  logic rv_q = 1'b0;
  always @(negedge clk) begin
    if (tx_underrun === 1'b1) n_underrun++;
    if (frame_abort === 1'b1) n_abort++;
    if (rx_valid === 1'b1 && rv_q !== 1'b1) begin
      n_rv_rise++;
      rv_rise_cyc = cyc;
    end
    rv_q = rx_valid;
  end

  // Frame-level reference model.
  logic [DATA_W-1:0] m_rx_data = '0, m_hold_data = '0;
  bit   m_rx_valid = 0, m_overrun = 0, m_hold_full = 0;
  int   m_underrun = 0, m_abort = 0, m_rv_rise = 0;
  int   last_rise_cyc = 0;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_rx_data = '0; m_hold_data = '0;
    m_rx_valid = 0; m_overrun = 0; m_hold_full = 0;
  endtask

  task automatic model_done(input logic [DATA_W-1:0] w);
    if (m_rx_valid) m_overrun = m_overrun | OVR_EN;
    else m_rv_rise++;
    m_rx_data  = w;
    m_rx_valid = 1;
  endtask

  task automatic push_tx(input logic [DATA_W-1:0] w);
    tx_data = w; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    m_hold_full = 1; m_hold_data = w;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_rx_valid = 0; m_overrun = 0;
  endtask

  // Drop select and predict which word the responder will reply with.
  task automatic ss_select(output logic [DATA_W-1:0] reply);
    ss_n = 1'b0;
    wait_clk(5);
    if (m_hold_full) begin
      reply = m_hold_data; m_hold_full = 0;
    end else begin
      reply = '0; m_underrun++;
    end
  endtask

  // Mode-0 master: mosi changes with sclk low, miso sampled at each rise.
  // With end_frame the final fall coincides with select going high.
  task automatic spi_bits(input logic [DATA_W-1:0] w, input int nbits, input int half,
                          input bit end_frame, output logic [DATA_W-1:0] got);
    logic [DATA_W-1:0] acc = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[DATA_W-1-i];
      wait_clk(half);
      acc = {acc[DATA_W-2:0], miso};
      sclk = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(half);
      if (end_frame && i == nbits - 1) ss_n = 1'b1;
      sclk = 1'b0;
    end
    mosi = 1'b0;
    got = acc;
    if (end_frame) wait_clk(8);
  endtask

  task automatic test_reset();
    logic [7:0] o;
    reset_n = 1'b0; sclk = 0; ss_n = 1; mosi = 0;
    tx_data = '0; tx_valid = 0; rx_ack = 0;
    wait_clk(3);
    o = {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, rx_overrun, busy};
    checks++; if (o !== 8'b0010_0000) begin errors++; $display("FAIL reset_outputs got %b expected %b", o, 8'b0010_0000); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_rx_data got %h expected 0", rx_data); end
    reset_n = 1'b1;
    wait_clk(8);
    o = {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, rx_overrun, busy};
    checks++; if (o !== 8'b0010_0000) begin errors++; $display("FAIL post_reset_outputs got %b expected %b", o, 8'b0010_0000); end
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] reply, got;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_tx_ready_pre got %b expected 1", tx_ready); end
    push_tx(32'hA5A5_0F0F);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_tx_ready_hs got %b expected 0", tx_ready); end
    ss_select(reply);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_tx_ready_start got %b expected 1", tx_ready); end
    checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL basic_miso_oe got %b expected 1", miso_oe); end
    spi_bits(32'h1234_5678, 32, 4, 1, got);
    model_done(32'h1234_5678);
    $display("basic: sent %h reply %h rx_data %h", 32'h1234_5678, got, rx_data);
    checks++; if (got !== reply) begin errors++; $display("FAIL basic_reply got %h expected %h", got, reply); end
    checks++; if (rx_data !== m_rx_data) begin errors++; $display("FAIL basic_rx_data got %h expected %h", rx_data, m_rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_rx_valid got %b expected 1", rx_valid); end
    checks++; if (rv_rise_cyc - last_rise_cyc !== 4) begin errors++; $display("FAIL basic_rx_latency got %0d expected 4", rv_rise_cyc - last_rise_cyc); end
    checks++; if (n_underrun !== m_underrun) begin errors++; $display("FAIL basic_underrun_cnt got %0d expected %0d", n_underrun, m_underrun); end
    do_ack();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_clear got %b expected 0", rx_valid); end
  endtask

  task automatic test_underrun();
    logic [DATA_W-1:0] reply, got;
    int u0 = n_underrun;
    ss_select(reply);
    spi_bits(32'hFFFF_FFFF, 32, 4, 1, got);
    model_done(32'hFFFF_FFFF);
    $display("underrun: reply %h rx_data %h pulses %0d", got, rx_data, n_underrun - u0);
    checks++; if (got !== 32'h0) begin errors++; $display("FAIL underrun_reply got %h expected 0", got); end
    checks++; if (n_underrun - u0 !== 1) begin errors++; $display("FAIL underrun_pulses got %0d expected 1", n_underrun - u0); end
    checks++; if (rx_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL underrun_rx_data got %h expected ffffffff", rx_data); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] r1, r2, g1, g2, w1, w2;
    int rv0 = n_rv_rise;
    w1 = $urandom; w2 = $urandom;
    push_tx(32'h0BAD_F00D);
    ss_select(r1);
    push_tx(32'hDEAD_BEEF);
    model_done(w1);
    fork
      spi_bits(w1, 32, 4, 0, g1);
      begin
        for (int k = 0; k < 400 && rx_valid !== 1'b1; k++) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid_timeout got %b expected 1", rx_valid); end
        else if (rx_data !== w1) begin errors++; $display("FAIL b2b_first_data got %h expected %h", rx_data, w1); end
        do_ack();
      end
    join
    r2 = m_hold_data; m_hold_full = 0;
    spi_bits(w2, 32, 4, 1, g2);
    model_done(w2);
    $display("b2b: replies %h %h rx_data %h valid_rises %0d", g1, g2, rx_data, n_rv_rise - rv0);
    checks++; if (g1 !== r1) begin errors++; $display("FAIL b2b_reply1 got %h expected %h", g1, r1); end
    checks++; if (g2 !== r2) begin errors++; $display("FAIL b2b_reply2 got %h expected %h", g2, r2); end
    checks++; if (rx_data !== w2) begin errors++; $display("FAIL b2b_rx_data got %h expected %h", rx_data, w2); end
    checks++; if (n_rv_rise - rv0 !== 2) begin errors++; $display("FAIL b2b_valid_rises got %0d expected 2", n_rv_rise - rv0); end
    do_ack();
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] reply, got, w;
    w = $urandom;
    ss_select(reply);
    spi_bits($urandom, 13, 4, 1, got);
    m_abort++;
    $display("abort: pulses %0d rx_data %h", n_abort, rx_data);
    checks++; if (n_abort !== m_abort) begin errors++; $display("FAIL abort_pulse got %0d expected %0d", n_abort, m_abort); end
    checks++; if (rx_data !== m_rx_data) begin errors++; $display("FAIL abort_rx_data got %h expected %h", rx_data, m_rx_data); end
    checks++; if (rx_valid !== m_rx_valid) begin errors++; $display("FAIL abort_rx_valid got %b expected %b", rx_valid, m_rx_valid); end
    ss_select(reply);
    spi_bits(w, 32, 4, 1, got);
    model_done(w);
    checks++; if (rx_data !== w) begin errors++; $display("FAIL abort_next_rx_data got %h expected %h", rx_data, w); end
    do_ack();
  endtask

  task automatic test_overrun();
    logic [DATA_W-1:0] reply, got, w1, w2;
    w1 = $urandom; w2 = $urandom;
    ss_select(reply); spi_bits(w1, 32, 5, 1, got); model_done(w1);
    ss_select(reply); spi_bits(w2, 32, 5, 1, got); model_done(w2);
    $display("overrun: flag %b rx_data %h", rx_overrun, rx_data);
    checks++; if (rx_overrun !== OVR_EN) begin errors++; $display("FAIL overrun_flag got %b expected %b", rx_overrun, OVR_EN); end
    checks++; if (rx_data !== w2) begin errors++; $display("FAIL overrun_rx_data got %h expected %h", rx_data, w2); end
    do_ack();
    checks++; if ({rx_overrun, rx_valid} !== 2'b00) begin errors++; $display("FAIL overrun_ack_clear got %b expected 00", {rx_overrun, rx_valid}); end
  endtask

  task automatic test_reset_midframe();
    logic [DATA_W-1:0] reply, got, w;
    logic [7:0] o;
    logic [4:0] p;
    w = $urandom;
    push_tx($urandom);
    ss_select(reply);
    spi_bits($urandom, 10, 4, 0, got);
    reset_n = 1'b0;
    wait_clk(2);
    model_reset();
    o = {miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, rx_overrun, busy};
    checks++; if (o !== 8'b0010_0000) begin errors++; $display("FAIL midreset_outputs got %b expected %b", o, 8'b0010_0000); end
    checks++; if (rx_data !== '0) begin errors++; $display("FAIL midreset_rx_data got %h expected 0", rx_data); end
    reset_n = 1'b1;
    spi_bits($urandom, 22, 4, 0, got);
    p = {miso_oe, busy, rx_valid, tx_ready, miso};
    checks++; if (p !== 5'b00010) begin errors++; $display("FAIL midreset_ignored got %b expected %b", p, 5'b00010); end
    ss_n = 1'b1;
    wait_clk(8);
    ss_select(reply);
    spi_bits(w, 32, 4, 1, got);
    model_done(w);
    $display("midreset: next frame rx_data %h reply %h", rx_data, got);
    checks++; if (rx_data !== w) begin errors++; $display("FAIL midreset_next_rx got %h expected %h", rx_data, w); end
    checks++; if (got !== reply) begin errors++; $display("FAIL midreset_next_reply got %h expected %h", got, reply); end
    do_ack();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] reply, got, w;
    for (int n = 0; n < 10; n++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) push_tx($urandom);
      if (m_rx_valid && $urandom_range(0, 1) == 1) do_ack();
      ss_select(reply);
      spi_bits(w, 32, $urandom_range(4, 6), 1, got);
      model_done(w);
      $display("random %0d: sent %h reply %h rx_data %h ovr %b", n, w, got, rx_data, rx_overrun);
      checks++; if (got !== reply) begin errors++; $display("FAIL rand_reply got %h expected %h", got, reply); end
      checks++; if (rx_data !== m_rx_data) begin errors++; $display("FAIL rand_rx_data got %h expected %h", rx_data, m_rx_data); end
      checks++; if ({rx_valid, rx_overrun} !== {m_rx_valid, m_overrun}) begin errors++; $display("FAIL rand_flags got %b expected %b", {rx_valid, rx_overrun}, {m_rx_valid, m_overrun}); end
      checks++; if (n_underrun !== m_underrun) begin errors++; $display("FAIL rand_underrun_cnt got %0d expected %0d", n_underrun, m_underrun); end
      checks++; if (tx_ready !== !m_hold_full) begin errors++; $display("FAIL rand_tx_ready got %b expected %b", tx_ready, !m_hold_full); end
      checks++; if (n_rv_rise !== m_rv_rise) begin errors++; $display("FAIL rand_valid_rises got %0d expected %0d", n_rv_rise, m_rv_rise); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
